pcileech_tlps128_cfg_requester: RTL
===================================

Name: pcileech_tlps128_cfg_requester

Overview:
- Single-outstanding PCIe configuration request initiator on the 128-bit TLP streams in the clk_pcie domain.
- Accepts a command (read or write, address, byte enables, data) and builds a CfgRd0/1 or CfgWr0/1 TLP in the same layout the shadow cfgspace consumes.
- Waits for the matching Cpl/CplD, then returns data and status, or reports a timeout.
- Serves as loopback stimulus for the shadow config space and for host-side config probing.

Parameters:
- TIMEOUT_CYCLES, 4096: clk_pcie cycles spent in WAIT before a timeout response; legal range 2..65535.

Ports:
- clk_pcie  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- pcie_id  in  16  this core's bus/dev/fn; used as requester ID.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high only in IDLE.
- cmd_wr  in  1  1 = CfgWr, 0 = CfgRd.
- cmd_type1  in  1  1 = Type1 (CfgRd1/CfgWr1).
- cmd_target  in  16  target bus/dev/fn.
- cmd_addr  in  10  DWORD address (byte address [11:2]).
- cmd_be  in  4  first-DW byte enables; bit n = byte n.
- cmd_data  in  32  write data.
- tx_tdata  out  128  TLP beat.
- tx_tkeepdw  out  4  valid DWs.
- tx_tvalid  out  1  TLP valid.
- tx_tlast  out  1  constant 1.
- tx_tready  in  1  sink accept.
- rx_tdata  in  128  incoming TLP beat.
- rx_tvalid  in  1  incoming valid.
- rx_tuser0  in  1  first-beat flag.
- rsp_valid  out  1  one-cycle response pulse.
- rsp_data  out  32  completion data (0 for writes, timeouts and errors).
- rsp_code  out  2  00 = SC, 01 = completion status non-zero, 10 = timeout.
- rsp_cpl_status  out  3  raw completion status field.
- rsp_tag  out  8  tag of the finished request.
- cnt_unmatched  out  16  saturating count of completions dropped while in WAIT.

Behaviour:
- Reset (async assert, sync release) forces:
  - state IDLE; tag counter 0; timeout counter 0; cnt_unmatched 0.
  - tx_tvalid 0; tx_tdata 0; tx_tkeepdw 0.
  - rsp_valid 0; rsp_data 0; rsp_code 0; rsp_cpl_status 0; rsp_tag 0.
  - cmd_ready 0 while rst is high.
- States: IDLE -> SEND -> WAIT -> RESP -> IDLE.
- IDLE:
  - cmd_ready = 1.
  - On cmd_valid, register the TLP and go to SEND; tx_tvalid rises the next cycle.
- TLP build (DW0 = tdata[31:0], DW1 = [63:32], DW2 = [95:64], DW3 = [127:96]):
  - [31:29] fmt: 000 for read, 010 for write. [28:24] type = 0010, then cmd_type1. [9:0] length = 1. All other DW0 bits are 0.
  - [35:32] = {be[0], be[1], be[2], be[3]}. [47:40] = tag. [63:48] = pcie_id.
  - [75:66] = cmd_addr. [95:80] = cmd_target. Remaining DW2 bits are 0.
  - [127:96] = cmd_data for writes, 0 for reads.
  - tx_tkeepdw = 1111 for writes, 0111 for reads.
- SEND:
  - tx_tvalid held with tdata/tkeepdw stable until a cycle with tx_tready = 1; then tvalid drops and state goes to WAIT.
  - Zero-wait acceptance is legal.
  - The timeout counter clears when entering WAIT.
- WAIT completion match, all required in the same cycle:
  - rx_tvalid & rx_tuser0.
  - rx_tdata[31:25] = 7'b0100101 (CplD) when the request was a read, or 7'b0000101 (Cpl) when it was a write.
  - rx_tdata[79:72] = tag.
  - rx_tdata[95:80] = pcie_id.
- Status field is rx_tdata[47:45].
- On a match, go to RESP with:
  - rsp_code = 00 if status == 0, else 01.
  - rsp_data = rx_tdata[127:96] only for a read with status 0; otherwise 0.
- Any other first beat with fmt/type Cpl or CplD seen in WAIT increments cnt_unmatched; the counter saturates at FFFF. Non-completion TLPs are ignored silently.
- Timeout:
  - The counter increments each WAIT cycle.
  - When it reaches TIMEOUT_CYCLES-1 with no match, go to RESP with rsp_code = 10, rsp_cpl_status = 0, rsp_data = 0.
  - A match in the same cycle as expiry wins.
- RESP:
  - rsp_valid = 1 for exactly one cycle, with rsp_tag = tag.
  - Tag increments modulo 256 (FF -> 00).
  - Return to IDLE; the earliest next cmd accept is the following cycle.
- Completions arriving in IDLE, SEND or RESP are ignored and not counted.
- Late completions for a timed-out tag arrive with an old tag: unmatched, counted if seen in WAIT.
- cmd_valid outside IDLE is ignored (cmd_ready = 0).

Test Plan:
- Reset mid-SEND, with tx_tvalid = 1 and tx_tready = 0 -> all outputs reset immediately; tag 0; a new cmd then issues tag 00.
- Read: pcie_id=0100, target=0200, addr=0x004, be=F, tag 00; TLP DW0=0x04000001, tkeepdw=0111; reply CplD DW0=0x4A000001, tag 00, reqid 0100, data 0xDEADBEEF -> rsp_valid one cycle, rsp_data DEADBEEF, rsp_code 00, rsp_tag 00.
- Write: cmd_type1=1, be=3, data 0x12345678 -> DW0=0x45000001, tdata[35:32]=1100, tkeepdw=1111; tx_tready low 5 cycles holds tdata stable; Cpl DW0=0x0A000000 status 000 -> rsp_code 00, rsp_data 0.
- Mismatch: in WAIT inject CplD with tag+1, then CplD with reqid 0101 -> cnt_unmatched = 2, no rsp; correct CplD with status 001 -> rsp_code 01, rsp_cpl_status 001, rsp_data 0.
- Timeout: TIMEOUT_CYCLES=16, no completion -> rsp_code 10 exactly 16 cycles after entering WAIT; correct CplD on the expiry cycle instead -> rsp_code 00.
- 257 back-to-back reads with immediate replies -> tags 00..FF then 00; cnt_unmatched stays 0.

Source files
------------

// File: rtl/pcileech_tlps128_cfg_requester.sv
// Single-outstanding PCIe config request initiator on 128-bit TLP streams.
// Builds CfgRd/CfgWr 0/1 TLPs, matches the returning Cpl/CplD, or times out.
module pcileech_tlps128_cfg_requester #(
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic         clk_pcie,
    input  logic         rst,
    input  logic [15:0]  pcie_id,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic         cmd_wr,
    input  logic         cmd_type1,
    input  logic [15:0]  cmd_target,
    input  logic [9:0]   cmd_addr,
    input  logic [3:0]   cmd_be,
    input  logic [31:0]  cmd_data,
    output logic [127:0] tx_tdata,
    output logic [3:0]   tx_tkeepdw,
    output logic         tx_tvalid,
    output logic         tx_tlast,
    input  logic         tx_tready,
    input  logic [127:0] rx_tdata,
    input  logic         rx_tvalid,
    input  logic         rx_tuser0,
    output logic         rsp_valid,
    output logic [31:0]  rsp_data,
    output logic [1:0]   rsp_code,
    output logic [2:0]   rsp_cpl_status,
    output logic [7:0]   rsp_tag,
    output logic [15:0]  cnt_unmatched
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEND,
        S_WAIT,
        S_RESP
    } state_t;

    localparam logic [6:0]  FT_CPLD  = 7'b0100101;
    localparam logic [6:0]  FT_CPL   = 7'b0000101;
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t         state_q, state_d;
    logic [7:0]     tag_q, tag_d;
    logic [15:0]    tmo_q, tmo_d;
    logic [15:0]    unm_q, unm_d;
    logic           wr_q, wr_d;
    logic [127:0]   tdata_q, tdata_d;
    logic [3:0]     keep_q, keep_d;
    logic [31:0]    rdata_q, rdata_d;
    logic [1:0]     rcode_q, rcode_d;
    logic [2:0]     rstat_q, rstat_d;
    logic [7:0]     rtag_q, rtag_d;

    logic [6:0] rx_ft;
    logic       rx_first;
    logic       rx_is_cpl;
    logic       rx_match;
    logic [2:0] rx_status;
    logic       unused_rx;

    assign rx_ft     = rx_tdata[31:25];
    assign rx_status = rx_tdata[47:45];
    assign rx_first  = rx_tvalid & rx_tuser0;
    assign rx_is_cpl = rx_first & ((rx_ft == FT_CPLD) | (rx_ft == FT_CPL));
    assign rx_match  = rx_first
                     & (rx_ft == (wr_q ? FT_CPL : FT_CPLD))
                     & (rx_tdata[79:72] == tag_q)
                     & (rx_tdata[95:80] == pcie_id);
    assign unused_rx = ^{rx_tdata[24:0], rx_tdata[44:32], rx_tdata[71:48]};

    always_comb begin
        state_d = state_q;
        tag_d   = tag_q;
        tmo_d   = tmo_q;
        unm_d   = unm_q;
        wr_d    = wr_q;
        tdata_d = tdata_q;
        keep_d  = keep_q;
        rdata_d = rdata_q;
        rcode_d = rcode_q;
        rstat_d = rstat_q;
        rtag_d  = rtag_q;
        unique case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    tdata_d          = '0;
                    tdata_d[31:29]   = cmd_wr ? 3'b010 : 3'b000;
                    tdata_d[28:24]   = {4'b0010, cmd_type1};
                    tdata_d[9:0]     = 10'd1;
                    tdata_d[35:32]   = {cmd_be[0], cmd_be[1],
                                        cmd_be[2], cmd_be[3]};
                    tdata_d[47:40]   = tag_q;
                    tdata_d[63:48]   = pcie_id;
                    tdata_d[75:66]   = cmd_addr;
                    tdata_d[95:80]   = cmd_target;
                    tdata_d[127:96]  = cmd_wr ? cmd_data : 32'h0;
                    keep_d           = cmd_wr ? 4'b1111 : 4'b0111;
                    wr_d             = cmd_wr;
                    state_d          = S_SEND;
                end
            end
            S_SEND: begin
                if (tx_tready) begin
                    tmo_d   = '0;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                tmo_d = tmo_q + 16'd1;
                // A match on the expiry cycle takes priority over the timeout
                if (rx_match) begin
                    rcode_d = (rx_status == 3'd0) ? 2'b00 : 2'b01;
                    rstat_d = rx_status;
                    rdata_d = (!wr_q && rx_status == 3'd0)
                            ? rx_tdata[127:96] : 32'h0;
                    rtag_d  = tag_q;
                    state_d = S_RESP;
                end else if (tmo_q == TMO_LAST) begin
                    rcode_d = 2'b10;
                    rstat_d = 3'd0;
                    rdata_d = 32'h0;
                    rtag_d  = tag_q;
                    state_d = S_RESP;
                end
                if (rx_is_cpl && !rx_match && unm_q != 16'hFFFF) begin
                    unm_d = unm_q + 16'd1;
                end
            end
            S_RESP: begin
                tag_d   = tag_q + 8'd1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_pcie or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            tag_q   <= '0;
            tmo_q   <= '0;
            unm_q   <= '0;
            wr_q    <= 1'b0;
            tdata_q <= '0;
            keep_q  <= '0;
            rdata_q <= '0;
            rcode_q <= '0;
            rstat_q <= '0;
            rtag_q  <= '0;
        end else begin
            state_q <= state_d;
            tag_q   <= tag_d;
            tmo_q   <= tmo_d;
            unm_q   <= unm_d;
            wr_q    <= wr_d;
            tdata_q <= tdata_d;
            keep_q  <= keep_d;
            rdata_q <= rdata_d;
            rcode_q <= rcode_d;
            rstat_q <= rstat_d;
            rtag_q  <= rtag_d;
        end
    end

    assign cmd_ready      = (state_q == S_IDLE) & ~rst;
    assign tx_tvalid      = (state_q == S_SEND);
    assign tx_tdata       = tdata_q;
    assign tx_tkeepdw     = keep_q;
    assign tx_tlast       = 1'b1;
    assign rsp_valid      = (state_q == S_RESP);
    assign rsp_data       = rdata_q;
    assign rsp_code       = rcode_q;
    assign rsp_cpl_status = rstat_q;
    assign rsp_tag        = rtag_q;
    assign cnt_unmatched  = unm_q;

endmodule
